hamming_enc_arbiter: RTL

- Shares one hamming_secded_encoder instance between two nibble requesters using round-robin arbitration.
- Registers the resulting 8-bit SECDED codeword and the source ID into a single-entry output stage with a valid/ready handshake.
- Provides one-shot error injection, so the downstream decoder can be exercised with controlled bit flips.
- Keeps a running count of delivered codewords.
- Sits between the input sources (switches/UART nibble splitter) and the transmit/decoder path.

---
 rtl/hamming_enc_arbiter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/hamming_enc_arbiter.sv
// -----------------------------------------------------------------------------
// hamming_enc_arbiter
//
// Purpose:
//   Two nibble requesters share one Hamming(7,4)+overall-parity (SECDED)
//   encoder. A round-robin arbiter picks a requester. The 8-bit codeword and
//   the requester ID go into a single-entry output register with a
//   valid/ready handshake. A one-shot XOR mask can be armed so that the next
//   accepted word carries deliberate bit flips for exercising a downstream
//   decoder. A wrapping counter tracks delivered codewords.
//
// Ports:
//   clk          system clock, all state on rising edge
//   rst          asynchronous active-high reset
//   req_valid    [1:0]  per-requester data valid (bit i = requester i)
//   req_data0    [3:0]  requester 0 nibble d3..d0
//   req_data1    [3:0]  requester 1 nibble d3..d0
//   req_ready    [1:0]  per-requester accept, at most one bit high
//   out_valid           output register holds a valid codeword
//   out_code     [7:0]  codeword {P,d3,d2,d1,p4,d0,p2,p1}
//   out_src             requester that produced out_code
//   out_ready           downstream accepts out_code
//   inj_arm             one-cycle pulse, captures inj_mask
//   inj_mask     [7:0]  XOR mask applied to the next accepted word
//   inj_pending         injection armed and not yet consumed
//   sent_cnt     [CNT_W-1:0] completed out_valid && out_ready transfers
// -----------------------------------------------------------------------------
module hamming_enc_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  input  logic [3:0]       req_data0,
  input  logic [3:0]       req_data1,
  output logic [1:0]       req_ready,
  output logic             out_valid,
  output logic [7:0]       out_code,
  output logic             out_src,
  input  logic             out_ready,
  input  logic             inj_arm,
  input  logic [7:0]       inj_mask,
  output logic             inj_pending,
  output logic [CNT_W-1:0] sent_cnt
);

  // Even parity over an arbitrary 7-bit vector.
  function automatic logic parity7(input logic [6:0] v);
    parity7 = ^v;
  endfunction

  // SECDED encoder: Hamming(7,4) positions 1..7 plus overall parity in bit 7.
  function automatic logic [7:0] hamming_secded_encode(input logic [3:0] d);
    logic       p1;
    logic       p2;
    logic       p4;
    logic [6:0] h;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p4 = d[1] ^ d[2] ^ d[3];
    h  = {d[3], d[2], d[1], p4, d[0], p2, p1};
    hamming_secded_encode = {parity7(h), h};
  endfunction

  // State registers.
  logic             out_valid_q,   out_valid_d;
  logic [7:0]       out_code_q,    out_code_d;
  logic             out_src_q,     out_src_d;
  logic             last_grant_q,  last_grant_d;
  logic             inj_pending_q, inj_pending_d;
  logic [7:0]       inj_mask_q,    inj_mask_d;
  logic [CNT_W-1:0] sent_cnt_q,    sent_cnt_d;

  // Combinational datapath.
  logic       load_s;
  logic       any_req_s;
  logic       grant_s;
  logic       accept_s;
  logic       drain_s;
  logic [3:0] sel_data_s;
  logic [7:0] enc_code_s;
  logic [7:0] apply_mask_s;

  // Output register is free, or empties this same cycle.
  assign load_s    = !out_valid_q || out_ready;
  assign any_req_s = |req_valid;
  assign accept_s  = load_s && any_req_s;
  assign drain_s   = out_valid_q && out_ready;

  // Round-robin grant; on a tie the requester that did not win last goes.
  always_comb begin
    grant_s = 1'b0;
    case (req_valid)
      2'b01:   grant_s = 1'b0;
      2'b10:   grant_s = 1'b1;
      2'b11:   grant_s = ~last_grant_q;
      default: grant_s = 1'b0;
    endcase
  end

  // Ready is only offered to the granted requester when the register can load.
  always_comb begin
    req_ready = 2'b00;
    if (accept_s) begin
      if (grant_s) begin
        req_ready = {req_valid[1], 1'b0};
      end else begin
        req_ready = {1'b0, req_valid[0]};
      end
    end else begin
      req_ready = 2'b00;
    end
  end

  // Shared encoder fed by the granted requester's nibble.
  always_comb begin
    sel_data_s   = grant_s ? req_data1 : req_data0;
    enc_code_s   = hamming_secded_encode(sel_data_s);
    apply_mask_s = inj_pending_q ? inj_mask_q : 8'h00;
  end

  // Output register next state: load new word, empty, or hold while stalled.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_code_d   = out_code_q;
    out_src_d    = out_src_q;
    last_grant_d = last_grant_q;
    if (load_s) begin
      if (any_req_s) begin
        out_valid_d  = 1'b1;
        out_code_d   = enc_code_s ^ apply_mask_s;
        out_src_d    = grant_s;
        last_grant_d = grant_s;
      end else begin
        out_valid_d  = 1'b0;
      end
    end else begin
      out_valid_d  = out_valid_q;
    end
  end

  // Injection: a new arm always wins (the word in flight uses the old mask);
  // otherwise an accept consumes a pending injection.
  always_comb begin
    inj_pending_d = inj_pending_q;
    inj_mask_d    = inj_mask_q;
    if (inj_arm) begin
      inj_pending_d = 1'b1;
      inj_mask_d    = inj_mask;
    end else if (accept_s && inj_pending_q) begin
      inj_pending_d = 1'b0;
    end else begin
      inj_pending_d = inj_pending_q;
    end
  end

  // Delivered-word counter, wraps naturally at 2^CNT_W.
  always_comb begin
    sent_cnt_d = sent_cnt_q;
    if (drain_s) begin
      sent_cnt_d = sent_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      sent_cnt_d = sent_cnt_q;
    end
  end

  // State flops; last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_code_q    <= 8'h00;
      out_src_q     <= 1'b0;
      last_grant_q  <= 1'b1;
      inj_pending_q <= 1'b0;
      inj_mask_q    <= 8'h00;
      sent_cnt_q    <= {CNT_W{1'b0}};
    end else begin
      out_valid_q   <= out_valid_d;
      out_code_q    <= out_code_d;
      out_src_q     <= out_src_d;
      last_grant_q  <= last_grant_d;
      inj_pending_q <= inj_pending_d;
      inj_mask_q    <= inj_mask_d;
      sent_cnt_q    <= sent_cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_code    = out_code_q;
  assign out_src     = out_src_q;
  assign inj_pending = inj_pending_q;
  assign sent_cnt    = sent_cnt_q;

endmodule
